// File: rtl/warp_pkg.sv
// rtl/warp_pkg.sv - shared modes, default widths and slicing helpers for the warp bilinear pipe
package warp_pkg;

    typedef enum logic [1:0] {
        MODE_BILINEAR = 2'd0,
        MODE_NEAREST  = 2'd1,
        MODE_BYPASS   = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    localparam int DEF_CH_NUM = 3;
    localparam int DEF_CH_W   = 8;
    localparam int DEF_FRAC_W = 10;
    localparam int DEF_XCNT_W = 12;
    localparam int DEF_YCNT_W = 12;
    localparam int DEF_WGT_W  = DEF_FRAC_W + 1;

    // Weights span 0..S inclusive, so one bit more than the fraction.
    function automatic int wgt_w(input int frac_w);
        return frac_w + 1;
    endfunction

    function automatic int hsum_w(input int ch_w, input int frac_w);
        return ch_w + frac_w + 1;
    endfunction

    function automatic int vsum_w(input int ch_w, input int frac_w);
        return ch_w + 2 * frac_w + 1;
    endfunction

    function automatic int ch_lsb(input int ch, input int ch_w);
        return ch * ch_w;
    endfunction

endpackage

// File: rtl/warp_bilinear_pipe_if.sv
// rtl/warp_bilinear_pipe_if.sv - neighbour-pixel input stream and output pixel stream bundle
interface warp_bilinear_pipe_if import warp_pkg::*; #(
    parameter int CH_NUM = DEF_CH_NUM,
    parameter int CH_W   = DEF_CH_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int XCNT_W = DEF_XCNT_W,
    parameter int YCNT_W = DEF_YCNT_W
);
    localparam int PIX_W = CH_NUM * CH_W;
    localparam int W_W   = FRAC_W + 1;

    logic              i_fsyn;
    logic [1:0]        iv_mode;
    logic [PIX_W-1:0]  iv_fill;
    logic              i_valid;
    logic              o_ready;
    logic [PIX_W-1:0]  iv_b11;
    logic [PIX_W-1:0]  iv_b12;
    logic [PIX_W-1:0]  iv_b21;
    logic [PIX_W-1:0]  iv_b22;
    logic [W_W-1:0]    iv_fx;
    logic [W_W-1:0]    iv_fy;
    logic              i_oob;
    logic              i_eol;
    logic              o_valid;
    logic              i_ready;
    logic [PIX_W-1:0]  ov_b;
    logic              o_eol;
    logic [XCNT_W-1:0] ov_xcnt;
    logic [YCNT_W-1:0] ov_ycnt;
    logic              o_fclamp;

    modport slave (
        input  i_fsyn, iv_mode, iv_fill, i_valid, iv_b11, iv_b12, iv_b21, iv_b22,
               iv_fx, iv_fy, i_oob, i_eol, i_ready,
        output o_ready, o_valid, ov_b, o_eol, ov_xcnt, ov_ycnt, o_fclamp
    );

    modport master (
        output i_fsyn, iv_mode, iv_fill, i_valid, iv_b11, iv_b12, iv_b21, iv_b22,
               iv_fx, iv_fy, i_oob, i_eol, i_ready,
        input  o_ready, o_valid, ov_b, o_eol, ov_xcnt, ov_ycnt, o_fclamp
    );

endinterface

// File: rtl/warp_lerp.sv
// rtl/warp_lerp.sv - single-channel two-point weighted sum a*w0 + b*w1
module warp_lerp #(
    parameter int A_W = 8,
    parameter int W_W = 11,
    parameter int O_W = 19
) (
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    input  logic [W_W-1:0] w0,
    input  logic [W_W-1:0] w1,
    output logic [O_W-1:0] y
);

    // w0 + w1 never exceeds S, so O_W only needs to hold max(a,b) * S.
    assign y = O_W'(a) * O_W'(w0) + O_W'(b) * O_W'(w1);

endmodule

// File: rtl/warp_bilinear_pipe.sv
// rtl/warp_bilinear_pipe.sv - 3-stage bilinear/nearest/bypass output stage with backpressure and x/y counters
module warp_bilinear_pipe import warp_pkg::*; #(
    parameter int CH_NUM = DEF_CH_NUM,
    parameter int CH_W   = DEF_CH_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int XCNT_W = DEF_XCNT_W,
    parameter int YCNT_W = DEF_YCNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    warp_bilinear_pipe_if.slave  bus
);
    localparam int PIX_W = CH_NUM * CH_W;
    localparam int W_W   = wgt_w(FRAC_W);
    localparam int H_W   = hsum_w(CH_W, FRAC_W);
    localparam int V_W   = vsum_w(CH_W, FRAC_W);

    localparam logic [W_W-1:0]    S_ONE  = W_W'(1) << FRAC_W;
    localparam logic [W_W-1:0]    S_HALF = W_W'(1) << (FRAC_W - 1);
    localparam logic [V_W:0]      RND    = (V_W + 1)'(1) << (2 * FRAC_W - 1);
    localparam logic [CH_W+1:0]   SAT    = (CH_W + 2)'((1 << CH_W) - 1);

    logic              stall, accept, clamp_hit;
    logic [W_W-1:0]    fx_c, fy_c;
    mode_e             mode_q, mode_eff;

    logic              s1_valid, s2_valid, out_valid;
    logic [PIX_W-1:0]  s1_b11, s1_b12, s1_b21, s1_b22, s1_fill;
    logic [W_W-1:0]    s1_fx, s1_fy, s1_wx0, s1_wy0;
    logic              s1_oob, s1_eol;

    logic [H_W-1:0]    ht_c [CH_NUM];
    logic [H_W-1:0]    hb_c [CH_NUM];
    logic [H_W-1:0]    s2_ht [CH_NUM];
    logic [H_W-1:0]    s2_hb [CH_NUM];
    logic [W_W-1:0]    s2_fy, s2_wy0;
    logic              s2_direct, s2_eol;
    logic [PIX_W-1:0]  s2_pix, near_pix, direct_pix;

    logic [V_W-1:0]    v_c  [CH_NUM];
    logic [V_W:0]      vr_c [CH_NUM];
    logic [CH_W+1:0]   q_c  [CH_NUM];
    logic [PIX_W-1:0]  lerp_pix;

    logic [PIX_W-1:0]  out_pix;
    logic              out_eol, fclamp;
    logic [XCNT_W-1:0] xcnt;
    logic [YCNT_W-1:0] ycnt;

    assign stall     = out_valid & ~bus.i_ready;
    assign accept    = bus.i_valid & ~stall;
    assign fx_c      = (bus.iv_fx > S_ONE) ? S_ONE : bus.iv_fx;
    assign fy_c      = (bus.iv_fy > S_ONE) ? S_ONE : bus.iv_fy;
    assign clamp_hit = accept & ((bus.iv_fx > S_ONE) | (bus.iv_fy > S_ONE));
    assign mode_eff  = (mode_q == MODE_NEAREST || mode_q == MODE_BYPASS) ? mode_q : MODE_BILINEAR;

    always_comb begin
        near_pix = s1_b11;
        if (s1_fx >= S_HALF) begin
            near_pix = (s1_fy >= S_HALF) ? s1_b22 : s1_b12;
        end else if (s1_fy >= S_HALF) begin
            near_pix = s1_b21;
        end
        direct_pix = near_pix;
        if (s1_oob) begin
            direct_pix = s1_fill;
        end else if (mode_eff == MODE_BYPASS) begin
            direct_pix = s1_b11;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        localparam int L = ch_lsb(c, CH_W);

        warp_lerp #(.A_W(CH_W), .W_W(W_W), .O_W(H_W)) u_top (
            .a(s1_b11[L +: CH_W]), .b(s1_b12[L +: CH_W]),
            .w0(s1_wx0), .w1(s1_fx), .y(ht_c[c])
        );
        warp_lerp #(.A_W(CH_W), .W_W(W_W), .O_W(H_W)) u_bot (
            .a(s1_b21[L +: CH_W]), .b(s1_b22[L +: CH_W]),
            .w0(s1_wx0), .w1(s1_fx), .y(hb_c[c])
        );
        warp_lerp #(.A_W(H_W), .W_W(W_W), .O_W(V_W)) u_vert (
            .a(s2_ht[c]), .b(s2_hb[c]),
            .w0(s2_wy0), .w1(s2_fy), .y(v_c[c])
        );

        // Round half up at S*S scale, then saturate to the channel range.
        assign vr_c[c] = (V_W + 1)'(v_c[c]) + RND;
        assign q_c[c]  = (CH_W + 2)'(vr_c[c] >> (2 * FRAC_W));
        assign lerp_pix[L +: CH_W] = (q_c[c] > SAT) ? {CH_W{1'b1}} : CH_W'(q_c[c]);
    end

    always_ff @(posedge i_clk) begin
        if (!stall) begin
            s1_b11    <= bus.iv_b11;
            s1_b12    <= bus.iv_b12;
            s1_b21    <= bus.iv_b21;
            s1_b22    <= bus.iv_b22;
            s1_fill   <= bus.iv_fill;
            s1_fx     <= fx_c;
            s1_fy     <= fy_c;
            s1_wx0    <= S_ONE - fx_c;
            s1_wy0    <= S_ONE - fy_c;
            s1_oob    <= bus.i_oob;
            s1_eol    <= bus.i_eol;
            s2_ht     <= ht_c;
            s2_hb     <= hb_c;
            s2_fy     <= s1_fy;
            s2_wy0    <= s1_wy0;
            s2_direct <= s1_oob | (mode_eff != MODE_BILINEAR);
            s2_pix    <= direct_pix;
            s2_eol    <= s1_eol;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_pix   <= '0;
            xcnt      <= '0;
            ycnt      <= '0;
            fclamp    <= 1'b0;
            mode_q    <= MODE_BILINEAR;
        end else if (bus.i_fsyn) begin
            // Old-frame beats are dropped; a beat arriving with the pulse opens the new frame.
            mode_q    <= mode_e'(bus.iv_mode);
            s1_valid  <= accept;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            xcnt      <= '0;
            ycnt      <= '0;
            fclamp    <= clamp_hit;
        end else begin
            if (!stall) begin
                s1_valid  <= accept;
                s2_valid  <= s1_valid;
                out_valid <= s2_valid;
                out_eol   <= s2_eol;
                out_pix   <= s2_direct ? s2_pix : lerp_pix;
            end
            if (clamp_hit) begin
                fclamp <= 1'b1;
            end
            if (out_valid && bus.i_ready) begin
                if (out_eol) begin
                    xcnt <= '0;
                    ycnt <= ycnt + 1'b1;
                end else begin
                    xcnt <= xcnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_ready  = ~stall;
    assign bus.o_valid  = out_valid;
    assign bus.ov_b     = out_pix;
    assign bus.o_eol    = out_eol;
    assign bus.ov_xcnt  = xcnt;
    assign bus.ov_ycnt  = ycnt;
    assign bus.o_fclamp = fclamp;

endmodule

// File: tb/tb_warp_bilinear_pipe.sv
// tb/tb_warp_bilinear_pipe.sv - directed vector bench for warp_bilinear_pipe
module tb_warp_bilinear_pipe;
    import warp_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    warp_bilinear_pipe_if bus ();
    warp_bilinear_pipe dut (.i_clk(clk), .i_reset(rstn), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [23:0] b11, b12, b21, b22;
        logic [10:0] fx, fy;
        logic        oob;
        logic [23:0] fill;
        logic [23:0] exp_b;
        logic        exp_clamp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rep(input logic [7:0] v);
        return {v, v, v};
    endfunction

    function automatic vec_t mk(input string n, input logic [1:0] m,
                                input logic [23:0] a, input logic [23:0] b,
                                input logic [23:0] c, input logic [23:0] d,
                                input logic [10:0] fx, input logic [10:0] fy,
                                input logic oob, input logic [23:0] fill,
                                input logic [23:0] e, input logic cl);
        vec_t v;
        v.name = n; v.mode = m; v.b11 = a; v.b12 = b; v.b21 = c; v.b22 = d;
        v.fx = fx; v.fy = fy; v.oob = oob; v.fill = fill; v.exp_b = e; v.exp_clamp = cl;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.i_fsyn = 1'b0; bus.iv_mode = 2'd0; bus.iv_fill = '0; bus.i_valid = 1'b0;
        bus.iv_b11 = '0; bus.iv_b12 = '0; bus.iv_b21 = '0; bus.iv_b22 = '0;
        bus.iv_fx = '0; bus.iv_fy = '0; bus.i_oob = 1'b0; bus.i_eol = 1'b0;
    endtask

    task automatic fsyn_pulse(input logic [1:0] m);
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_fsyn = 1'b1; bus.iv_mode = m;
        @(negedge clk);
        bus.i_fsyn = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit do_fsyn);
        int lat;
        if (do_fsyn) fsyn_pulse(v.mode);
        else @(negedge clk);
        bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_eol = 1'b0;
        bus.iv_b11 = v.b11; bus.iv_b12 = v.b12; bus.iv_b21 = v.b21; bus.iv_b22 = v.b22;
        bus.iv_fx = v.fx; bus.iv_fy = v.fy; bus.i_oob = v.oob; bus.iv_fill = v.fill;
        lat = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.i_valid = 1'b0;
            if (bus.o_valid) lat = n;
        end
        check({v.name, "_lat"}, lat, 3);
        check({v.name, "_pix"}, bus.ov_b, v.exp_b);
        check({v.name, "_fclamp"}, bus.o_fclamp, v.exp_clamp);
        bus.i_oob = 1'b0;
    endtask

    // Streams 8 bypass beats (values 1..8, eol every 4th); bp toggles i_ready 1,0,0,1.
    task automatic run_stream(input bit bp);
        int sent, got, cyc, rdy_err, extra;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent = 0; got = 0; cyc = 0; rdy_err = 0; extra = 0;
        bus.iv_fx = '0; bus.iv_fy = '0; bus.i_oob = 1'b0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            bus.i_ready = bp ? pat[cyc % 4] : 1'b1;
            if (sent < 8) begin
                bus.i_valid = 1'b1;
                bus.iv_b11 = rep(8'(sent + 1));
                bus.i_eol = (sent % 4 == 3);
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (bus.o_ready !== ~(bus.o_valid & ~bus.i_ready)) rdy_err++;
            if (bus.o_valid && bus.i_ready) begin
                check($sformatf("bp%0d_data%0d", bp, got), bus.ov_b, rep(8'(got + 1)));
                check($sformatf("bp%0d_x%0d", bp, got), bus.ov_xcnt, got % 4);
                check($sformatf("bp%0d_y%0d", bp, got), bus.ov_ycnt, got / 4);
                check($sformatf("bp%0d_eol%0d", bp, got), bus.o_eol, (got % 4 == 3));
                got++;
            end
            if (bus.i_valid && bus.o_ready) sent++;
            cyc++;
        end
        bus.i_valid = 1'b0; bus.i_eol = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); bus.i_ready = 1'b1; #1;
            if (bus.o_valid) extra++;
        end
        check($sformatf("bp%0d_count", bp), got, 8);
        check($sformatf("bp%0d_oready", bp), rdy_err, 0);
        check($sformatf("bp%0d_extra", bp), extra, 0);
    endtask

    initial begin
        int lat, nvalid;
        logic [23:0] first_pix;
        logic [11:0] first_x, first_y;

        vecs[0]  = mk("bil_centre", 2'd0, rep(10), rep(20), rep(30), rep(40), 11'd512, 11'd512, 0, 0, rep(25), 0);
        vecs[1]  = mk("half_up",    2'd0, 0, rep(1), 0, 0, 11'd512, 11'd0, 0, 0, rep(1), 0);
        vecs[2]  = mk("round_down", 2'd0, 0, rep(255), 0, 0, 11'd1, 11'd0, 0, 0, 24'h0, 0);
        vecs[3]  = mk("full_255",   2'd0, rep(255), rep(255), rep(255), rep(255), 11'd1024, 11'd1024, 0, 0, rep(255), 0);
        vecs[4]  = mk("fx_clamp",   2'd0, rep(10), rep(200), 0, 0, 11'd1500, 11'd0, 0, 0, rep(200), 1);
        vecs[5]  = mk("per_chan",   2'd0, 24'h00640A, 24'hFF6414, 24'h00641E, 24'hFF6428, 11'd512, 11'd512, 0, 0, 24'h806419, 0);
        vecs[6]  = mk("near_b21",   2'd1, rep(1), rep(2), rep(3), rep(4), 11'd511, 11'd600, 0, 0, rep(3), 0);
        vecs[7]  = mk("near_b22",   2'd1, rep(1), rep(2), rep(3), rep(4), 11'd512, 11'd600, 0, 0, rep(4), 0);
        vecs[8]  = mk("near_b11",   2'd1, rep(1), rep(2), rep(3), rep(4), 11'd0, 11'd511, 0, 0, rep(1), 0);
        vecs[9]  = mk("bypass",     2'd2, 24'h0A0B0C, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 11'd512, 11'd512, 0, 0, 24'h0A0B0C, 0);
        vecs[10] = mk("oob_bil",    2'd0, rep(10), rep(20), rep(30), rep(40), 11'd512, 11'd512, 1, 24'h123456, 24'h123456, 0);
        vecs[11] = mk("oob_near",   2'd1, rep(1), rep(2), rep(3), rep(4), 11'd512, 11'd600, 1, 24'h654321, 24'h654321, 0);
        vecs[12] = mk("rsvd_mode",  2'd3, rep(10), rep(20), rep(30), rep(40), 11'd512, 11'd512, 0, 0, rep(25), 0);
        vecs[13] = mk("fy_clamp",   2'd0, rep(5), 0, rep(77), 0, 11'd0, 11'd2047, 0, 0, rep(77), 1);

        idle_inputs();
        bus.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.o_valid, 0);
        check("rst_pix", bus.ov_b, 0);
        check("rst_eol", bus.o_eol, 0);
        check("rst_xcnt", bus.ov_xcnt, 0);
        check("rst_ycnt", bus.ov_ycnt, 0);
        check("rst_fclamp", bus.o_fclamp, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_oready", bus.o_ready, 1);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], 1'b1);

        fsyn_pulse(MODE_NEAREST);
        bus.iv_mode = MODE_BYPASS;
        run_vec(vecs[6], 1'b0);

        fsyn_pulse(MODE_BYPASS);
        run_stream(1'b0);
        fsyn_pulse(MODE_BYPASS);
        run_stream(1'b1);
        check("pre_flush_ycnt", bus.ov_ycnt, 2);

        @(negedge clk);
        bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.iv_b11 = rep(8'hAA);
        @(negedge clk);
        bus.iv_b11 = rep(8'hBB);
        @(negedge clk);
        bus.i_fsyn = 1'b1; bus.iv_mode = MODE_BYPASS; bus.iv_b11 = rep(8'hCC);
        lat = 0; nvalid = 0; first_pix = '0; first_x = '0; first_y = '0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                bus.i_fsyn = 1'b0; bus.i_valid = 1'b0;
                check("flush_valid", bus.o_valid, 0);
                check("flush_xcnt", bus.ov_xcnt, 0);
                check("flush_ycnt", bus.ov_ycnt, 0);
            end
            if (bus.o_valid) begin
                if (nvalid == 0) begin
                    lat = n; first_pix = bus.ov_b; first_x = bus.ov_xcnt; first_y = bus.ov_ycnt;
                end
                nvalid++;
            end
        end
        check("flush_lat", lat, 3);
        check("flush_pix", first_pix, rep(8'hCC));
        check("flush_x", first_x, 0);
        check("flush_y", first_y, 0);
        check("flush_nvalid", nvalid, 1);

        @(negedge clk);
        bus.i_valid = 1'b1; bus.iv_b11 = rep(8'h09);
        @(negedge clk);
        bus.i_valid = 1'b0; rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.o_valid) nvalid++;
        end
        check("midrst_nvalid", nvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/warp_bilinear_pipe.md
Name: warp_bilinear_pipe

Overview:
- Parametrised successor to the fixed 16-bit bilinear output stage of the rotation pipeline. It sits after the fx/fy and neighbour-pixel buffer and produces the rotated output pixel stream.
- Generalised to CH_NUM channels of CH_W bits and FRAC_W fractional bits.
- Adds a 3-stage pipelined datapath with valid/ready backpressure, run-time interpolation mode, out-of-bounds fill, and output x/y position counters.

Parameters:
- CH_NUM, 3, number of colour channels per pixel
- CH_W, 8, bits per channel
- FRAC_W, 10, fractional weight bits; S = 2^FRAC_W represents 1.0
- XCNT_W, 12, output column counter width
- YCNT_W, 12, output row counter width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_fsyn  in  1  one-cycle start-of-frame pulse
- iv_mode  in  2  0 bilinear, 1 nearest, 2 bypass (b11), 3 reserved (treated as bilinear)
- iv_fill  in  CH_NUM*CH_W  colour output for out-of-bounds pixels
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat
- iv_b11, iv_b12, iv_b21, iv_b22  in  CH_NUM*CH_W each  top-left, top-right, bottom-left, bottom-right neighbours; channel 0 in the LSBs
- iv_fx, iv_fy  in  FRAC_W+1  fractional offsets, 0..S
- i_oob  in  1  source point lies outside the image
- i_eol  in  1  last pixel of the output line
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- ov_b  out  CH_NUM*CH_W  output pixel
- o_eol  out  1  end-of-line, aligned with ov_b
- ov_xcnt  out  XCNT_W  column index of the current ov_b
- ov_ycnt  out  YCNT_W  row index of the current ov_b
- o_fclamp  out  1  sticky flag: fx or fy above S was seen this frame

Behaviour:
- Reset (i_reset=0 at an i_clk edge):
  - all pipeline valids, o_valid, o_eol, ov_b, ov_xcnt, ov_ycnt and o_fclamp go to 0;
  - the latched mode goes to bilinear;
  - o_ready is 1 in the cycle after reset is released.
- Handshake and stall:
  - A beat transfers when valid and ready are both 1.
  - The pipeline uses a global stall: stall = o_valid & ~i_ready; every stage register holds while stall=1.
  - o_ready = ~stall (combinational). This gives full throughput of 1 beat/clk when not stalled.
  - Latency is exactly 3 cycles from input transfer to o_valid when never stalled.
  - Empty stages are bubbles and propagate, so a beat advances even if a later stage is empty.
- Frame start (i_fsyn=1):
  - flushes all stage valids, clears o_valid, ov_xcnt, ov_ycnt and o_fclamp, and latches iv_mode;
  - an input beat presented in the same cycle is accepted as the first beat of the new frame;
  - the mode never changes mid-frame.
- Weight clamp: fx or fy above S is clamped to S and sets o_fclamp.
- Stage 1: register the inputs, the clamped weights, wx0 = S-fx and wy0 = S-fy.
- Stage 2, per channel (horizontal): ht = b11*wx0 + b12*fx and hb = b21*wx0 + b22*fx; width CH_W+FRAC_W+1, unsigned.
- Stage 3, per channel (vertical): v = ht*wy0 + hb*fy; width CH_W+2*FRAC_W+1.
- Rounding: out = (v + 2^(2*FRAC_W-1)) >> (2*FRAC_W), round half up, then saturated to 2^CH_W-1.
- Nearest mode: selects b11/b12/b21/b22 by fx >= S/2 and fy >= S/2; output is still registered through 3 stages.
- Bypass mode: outputs b11.
- Out-of-bounds: i_oob=1 forces ov_b = iv_fill regardless of mode; iv_fill is sampled with the beat in stage 1.
- Counters:
  - Counters describe the beat on ov_b.
  - On each output transfer, ov_xcnt increments. If o_eol, ov_xcnt goes to 0 and ov_ycnt increments instead.
  - Both counters wrap modulo 2^width with no flag.
- Reset asserted mid-frame discards all in-flight beats.

Decomposition:
- Shared package warp_pkg:
  - mode constants MODE_BILINEAR, MODE_NEAREST, MODE_BYPASS;
  - the channel slicing function;
  - the weight-width localparams.
- One sub-module, warp_lerp: a single-channel two-point weighted sum a*w0 + b*w1 with parametrised input and weight widths.
  - Stage 2 uses 2*CH_NUM instances; stage 3 uses CH_NUM instances with widened inputs.

Test Plan:
All cases use the defaults (CH_W=8, FRAC_W=10, S=1024).
1. Bilinear centre: b11=10, b12=20, b21=30, b22=40, fx=fy=512 → ov_b = 25 on every channel, o_valid exactly 3 clks after the transfer.
2. Rounding and clamp:
   - b11=0, b12=1, fx=512, fy=0 → 1 (half rounds up);
   - b11=b12=b21=b22=255, fx=fy=1024 → 255, no overflow;
   - fx=1500 → treated as 1024 and o_fclamp=1.
3. Modes:
   - nearest with fx=511, fy=600 → b21; fx=512, fy=600 → b22;
   - iv_mode changed mid-frame has no effect until the next i_fsyn;
   - i_oob=1 with iv_fill=0x123456 → 0x123456.
4. Backpressure: stream 8 beats with values 1..8 while i_ready toggles 1,0,0,1,… → all 8 delivered in order, none lost or duplicated; o_ready=0 exactly when o_valid=1 and i_ready=0.
5. Counters: 2 lines of 4 pixels with i_eol on each 4th beat → (ov_xcnt, ov_ycnt) runs (0,0)…(3,0), (0,1)…(3,1); o_eol is 1 at x=3.
6. i_fsyn with 2 beats in flight → those beats never appear, counters are 0, and a beat accepted in the i_fsyn cycle emerges 3 clks later with (0,0).
